io_port_hub: RTL and testbench
==============================

# io_port_hub

Parametrised I/O port hub between the processor's PicoBlaze-style I/O bus and `NUM_CH` rs232_uart channels, plus a GPIO port. It replaces the fixed three-port decode in `top`. It adds the following:
- strobe edge detection, so every access produces exactly one UART pulse;
- registered TX writes;
- sticky error flags and a saturating per-channel drop counter;
- a synchronised GPIO input;
- a maskable RX-data interrupt.

## Interface
Parameters:
- `NUM_CH`, default 2: number of UART channels, 1..8.
- `PORT_BASE`, default 8'h01: port of channel 0's data register. `PORT_BASE + 4*NUM_CH` must be ≤ 8'hF0.
- `GPIO_WID`, default 8: GPIO width, 1..8.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `IO_port_ID` in 8: port address from the processor.
- `IO_write_data` in 8: write data from the processor.
- `IO_write_strobe` in 1: processor write strobe.
- `IO_read_strobe` in 1: processor read strobe.
- `IO_read_data` out 8: read data to the processor, combinational.
- `uart_tx_data` out 8*NUM_CH: TX byte; channel k is in bits [8k+7:8k].
- `uart_tx_write` out NUM_CH: per-channel write_tx_data pulse.
- `uart_tx_full` in NUM_CH: per-channel tx_buffer_full.
- `uart_rx_data` in 8*NUM_CH: per-channel rx_data_out.
- `uart_rx_present` in NUM_CH: per-channel rx_data_present.
- `uart_rx_ack` out NUM_CH: per-channel read_rx_data_ack pulse.
- `gpio_in` in GPIO_WID: asynchronous inputs.
- `gpio_out` out GPIO_WID: GPIO output register.
- `irq` out 1: registered interrupt request.

## Operation
Port map. Channel k has base address B = PORT_BASE + 4k.
- B+0, DATA:
  - Read returns `uart_rx_data[k]`.
  - Write sends a byte to TX.
- B+1, STATUS:
  - Read returns {4'b0, rx_underrun, tx_drop, tx_full, rx_present}.
  - Write clears sticky flags: bit2=1 clears tx_drop; bit3=1 clears rx_underrun.
- B+2, DROPCNT: read returns an 8-bit saturating count of dropped TX writes. Write clears it to 0.
- B+3, CTRL: bit0 is rx_irq_en, read/write. Other bits read 0.
- 8'hF0: write loads `gpio_out` with `IO_write_data[GPIO_WID-1:0]`. Read returns the synchronised `gpio_in`, zero-extended.
- 8'hF1: read returns NUM_CH. Writes are ignored.
- Any unmapped port reads 8'h00. Writes to unmapped ports are ignored.

Access events:
- An access event is the first cycle of a strobe. A register stores each strobe's previous value; an event is `strobe & ~prev`.
- A strobe held high for several cycles is one access, even if `IO_port_ID` changes while it is held.

Write to DATA:
- If `uart_tx_full[k]=0` at the event, then on the next cycle `uart_tx_write[k]=1` for exactly one cycle and `uart_tx_data[k]` holds the byte.
- If `uart_tx_full[k]=1`, there is no pulse. tx_drop is set and DROPCNT increments, saturating at 255.

Read from DATA:
- `IO_read_data` is combinational. It is 8'h00 whenever `IO_read_strobe=0`.
- If rx_present=1 at the event, `uart_rx_ack[k]=1` for exactly the next cycle.
- If rx_present=0, the read returns `uart_rx_data[k]`, there is no ack, and rx_underrun is set.

Sticky flag priority: if a set and a clear of the same flag occur in the same cycle, set wins.

Interrupt: `irq` is registered and equals OR over k of (`uart_rx_present[k]` & rx_irq_en[k]).

GPIO input: `gpio_in` passes through a 2-flop synchroniser.

Reset values (all synchronous):
- `uart_tx_write`=0, `uart_rx_ack`=0, `uart_tx_data`=0.
- `gpio_out`=0, `irq`=0.
- Sticky flags, DROPCNT, rx_irq_en, strobe history and synchroniser flops are all 0.

Reset mid-operation: a pending TX pulse or RX ack scheduled for the next cycle is cancelled.

## Timing
- Read data: 0-cycle latency; valid in the same cycle as the strobe.
- `uart_rx_ack`: strobe-rise cycle + 1, width exactly 1.
- `uart_tx_write` and `uart_tx_data`: strobe-rise cycle + 1, width exactly 1. `uart_tx_data` holds its value until the next write.
- STATUS and DROPCNT: updates are visible to a read 1 cycle after the causing event.
- `irq`: follows the rx_present/enable combination with 1-cycle latency.
- `gpio_in` to readable value: 2 cycles.
- `gpio_out`: updates 1 cycle after the write event.
- Back-to-back accesses need the strobe low for at least one cycle between them.
- Read and write events in the same cycle are handled independently.

## Test plan
- Write 8'h41 to port 8'h01 with strobe held 3 cycles, tx_full=0 -> exactly one `uart_tx_write[0]` pulse at cycle+1, `uart_tx_data[7:0]`=8'h41.
- Write to port 8'h05 (channel 1) with `uart_tx_full[1]`=1, 300 times:
  - no pulses;
  - STATUS read of 8'h06 returns 8'h04;
  - DROPCNT (8'h07) reads 8'hFF;
  - write 8'h04 to 8'h06 -> STATUS reads 8'h00.
- rx_present[0]=1, rx_data=8'h5A, read 8'h01 -> `IO_read_data`=8'h5A in the same cycle, single ack at +1. With rx_present=0 -> no ack; STATUS 8'h02 reads 8'h08.
- Write 8'h01 to 8'h04 (CTRL0), assert rx_present[0] -> `irq`=1 after 1 cycle; clear CTRL0 -> `irq`=0 after 1 cycle.
- `gpio_in`=8'hA5 -> read 8'hF0 returns 8'hA5 from cycle 2 onward. Write 8'h3C to 8'hF0 -> `gpio_out`=8'h3C. Read 8'hF1 -> 8'h02.
- Assert `reset` in the cycle after a DATA write event -> no `uart_tx_write` pulse; all outputs are 0 next cycle.

Source files
------------

// File: rtl/io_port_hub.sv
`default_nettype none
// ============================================================================
// io_port_hub : PicoBlaze-style I/O bus decoder for NUM_CH UART channels + GPIO
// Revision    : 1.0
// ============================================================================
module io_port_hub #(
    parameter int         NUM_CH    = 2,
    parameter logic [7:0] PORT_BASE = 8'h01,
    parameter int         GPIO_WID  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            IO_port_ID,
    input  logic [7:0]            IO_write_data,
    input  logic                  IO_write_strobe,
    input  logic                  IO_read_strobe,
    output logic [7:0]            IO_read_data,
    output logic [8*NUM_CH-1:0]   uart_tx_data,
    output logic [NUM_CH-1:0]     uart_tx_write,
    input  logic [NUM_CH-1:0]     uart_tx_full,
    input  logic [8*NUM_CH-1:0]   uart_rx_data,
    input  logic [NUM_CH-1:0]     uart_rx_present,
    output logic [NUM_CH-1:0]     uart_rx_ack,
    input  logic [GPIO_WID-1:0]   gpio_in,
    output logic [GPIO_WID-1:0]   gpio_out,
    output logic                  irq
);

    localparam logic [7:0] GPIO_PORT = 8'hF0;
    localparam logic [7:0] INFO_PORT = 8'hF1;

    logic                    rd_prev_q, wr_prev_q;
    logic                    w_rd_ev, w_wr_ev;
    logic [NUM_CH-1:0]       w_hit_data, w_hit_stat, w_hit_cnt, w_hit_ctrl;
    logic [8*NUM_CH-1:0]     tx_data_q, tx_data_d;
    logic [NUM_CH-1:0]       tx_write_q, tx_write_d;
    logic [NUM_CH-1:0]       rx_ack_q, rx_ack_d;
    logic [NUM_CH-1:0]       tx_drop_q, tx_drop_d;
    logic [NUM_CH-1:0]       rx_unr_q, rx_unr_d;
    logic [NUM_CH-1:0]       irq_en_q, irq_en_d;
    logic [NUM_CH-1:0][7:0]  dropcnt_q, dropcnt_d;
    logic [GPIO_WID-1:0]     gpio_s1_q, gpio_s2_q;
    logic [GPIO_WID-1:0]     gpio_out_q, gpio_out_d;
    logic                    irq_q;
    logic [7:0]              w_rd_mux;

    assign w_rd_ev = IO_read_strobe  & ~rd_prev_q;
    assign w_wr_ev = IO_write_strobe & ~wr_prev_q;

    always_comb begin
        w_hit_data = '0;
        w_hit_stat = '0;
        w_hit_cnt  = '0;
        w_hit_ctrl = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_hit_data[k] = (IO_port_ID == PORT_BASE + 8'(4*k));
            w_hit_stat[k] = (IO_port_ID == PORT_BASE + 8'(4*k + 1));
            w_hit_cnt[k]  = (IO_port_ID == PORT_BASE + 8'(4*k + 2));
            w_hit_ctrl[k] = (IO_port_ID == PORT_BASE + 8'(4*k + 3));
        end
    end

    always_comb begin
        tx_data_d  = tx_data_q;
        tx_write_d = '0;
        rx_ack_d   = '0;
        tx_drop_d  = tx_drop_q;
        rx_unr_d   = rx_unr_q;
        irq_en_d   = irq_en_q;
        dropcnt_d  = dropcnt_q;
        gpio_out_d = gpio_out_q;
        for (int k = 0; k < NUM_CH; k++) begin
            // Clears are evaluated before sets so a coincident set wins.
            if (w_wr_ev && w_hit_stat[k]) begin
                if (IO_write_data[2]) tx_drop_d[k] = 1'b0;
                if (IO_write_data[3]) rx_unr_d[k]  = 1'b0;
            end
            if (w_wr_ev && w_hit_cnt[k])  dropcnt_d[k] = 8'h00;
            if (w_wr_ev && w_hit_ctrl[k]) irq_en_d[k]  = IO_write_data[0];
            if (w_wr_ev && w_hit_data[k]) begin
                if (uart_tx_full[k]) begin
                    tx_drop_d[k] = 1'b1;
                    if (dropcnt_q[k] != 8'hFF) dropcnt_d[k] = dropcnt_q[k] + 8'd1;
                end else begin
                    tx_write_d[k]       = 1'b1;
                    tx_data_d[8*k +: 8] = IO_write_data;
                end
            end
            if (w_rd_ev && w_hit_data[k]) begin
                if (uart_rx_present[k]) rx_ack_d[k] = 1'b1;
                else                    rx_unr_d[k] = 1'b1;
            end
        end
        if (w_wr_ev && (IO_port_ID == GPIO_PORT)) gpio_out_d = IO_write_data[GPIO_WID-1:0];
    end

    always_comb begin
        w_rd_mux = 8'h00;
        if (IO_port_ID == GPIO_PORT) w_rd_mux = 8'(gpio_s2_q);
        if (IO_port_ID == INFO_PORT) w_rd_mux = 8'(NUM_CH);
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_hit_data[k]) w_rd_mux = uart_rx_data[8*k +: 8];
            if (w_hit_stat[k]) w_rd_mux = {4'b0000, rx_unr_q[k], tx_drop_q[k],
                                           uart_tx_full[k], uart_rx_present[k]};
            if (w_hit_cnt[k])  w_rd_mux = dropcnt_q[k];
            if (w_hit_ctrl[k]) w_rd_mux = {7'b0000000, irq_en_q[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_prev_q  <= 1'b0;
            wr_prev_q  <= 1'b0;
            tx_data_q  <= '0;
            tx_write_q <= '0;
            rx_ack_q   <= '0;
            tx_drop_q  <= '0;
            rx_unr_q   <= '0;
            irq_en_q   <= '0;
            dropcnt_q  <= '0;
            gpio_s1_q  <= '0;
            gpio_s2_q  <= '0;
            gpio_out_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            rd_prev_q  <= IO_read_strobe;
            wr_prev_q  <= IO_write_strobe;
            tx_data_q  <= tx_data_d;
            tx_write_q <= tx_write_d;
            rx_ack_q   <= rx_ack_d;
            tx_drop_q  <= tx_drop_d;
            rx_unr_q   <= rx_unr_d;
            irq_en_q   <= irq_en_d;
            dropcnt_q  <= dropcnt_d;
            gpio_s1_q  <= gpio_in;
            gpio_s2_q  <= gpio_s1_q;
            gpio_out_q <= gpio_out_d;
            irq_q      <= |(uart_rx_present & irq_en_q);
        end
    end

    // Reset also masks a pulse already sitting in its register so it never reaches a UART.
    assign uart_tx_write = tx_write_q & {NUM_CH{~reset}};
    assign uart_rx_ack   = rx_ack_q   & {NUM_CH{~reset}};
    assign uart_tx_data  = tx_data_q;
    assign gpio_out      = gpio_out_q;
    assign irq           = irq_q;
    assign IO_read_data  = IO_read_strobe ? w_rd_mux : 8'h00;

endmodule
`default_nettype wire

// File: tb/tb_io_port_hub.sv
`default_nettype none
// ============================================================================
// tb_io_port_hub : scoreboard bench for io_port_hub (NUM_CH=2, PORT_BASE=01)
// Revision       : 1.0
// ============================================================================
module tb_io_port_hub;

    localparam int NUM_CH   = 2;
    localparam int GPIO_WID = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [7:0]            IO_port_ID;
    logic [7:0]            IO_write_data;
    logic                  IO_write_strobe;
    logic                  IO_read_strobe;
    logic [7:0]            IO_read_data;
    logic [8*NUM_CH-1:0]   uart_tx_data;
    logic [NUM_CH-1:0]     uart_tx_write;
    logic [NUM_CH-1:0]     uart_tx_full;
    logic [8*NUM_CH-1:0]   uart_rx_data;
    logic [NUM_CH-1:0]     uart_rx_present;
    logic [NUM_CH-1:0]     uart_rx_ack;
    logic [GPIO_WID-1:0]   gpio_in;
    logic [GPIO_WID-1:0]   gpio_out;
    logic                  irq;

    io_port_hub #(.NUM_CH(NUM_CH), .PORT_BASE(8'h01), .GPIO_WID(GPIO_WID)) dut (
        .clk             (clk),
        .reset           (reset),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .IO_read_data    (IO_read_data),
        .uart_tx_data    (uart_tx_data),
        .uart_tx_write   (uart_tx_write),
        .uart_tx_full    (uart_tx_full),
        .uart_rx_data    (uart_rx_data),
        .uart_rx_present (uart_rx_present),
        .uart_rx_ack     (uart_rx_ack),
        .gpio_in         (gpio_in),
        .gpio_out        (gpio_out),
        .irq             (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        int         ch;
        logic [7:0] data;
    } exp_t;

    exp_t tx_q[$];
    exp_t ack_q[$];
    exp_t rd_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every output event pops its expectation.
    always @(negedge clk) begin : mon
        exp_t              e;
        logic [NUM_CH-1:0] m;
        if (|uart_tx_write) begin
            checks++;
            if (tx_q.size() == 0) begin
                errors++;
                $display("FAIL tx_write: unexpected pulse mask=%b cycle %0d", uart_tx_write, cyc);
            end else begin
                e = tx_q.pop_front();
                m = '0;
                m[e.ch] = 1'b1;
                if (e.cyc != cyc || uart_tx_write != m || uart_tx_data[8*e.ch +: 8] != e.data) begin
                    errors++;
                    $display("FAIL tx_write: got cyc=%0d mask=%b data=%h expected cyc=%0d mask=%b data=%h",
                             cyc, uart_tx_write, uart_tx_data[8*e.ch +: 8], e.cyc, m, e.data);
                end
            end
        end
        if (|uart_rx_ack) begin
            checks++;
            if (ack_q.size() == 0) begin
                errors++;
                $display("FAIL rx_ack: unexpected pulse mask=%b cycle %0d", uart_rx_ack, cyc);
            end else begin
                e = ack_q.pop_front();
                m = '0;
                m[e.ch] = 1'b1;
                if (e.cyc != cyc || uart_rx_ack != m) begin
                    errors++;
                    $display("FAIL rx_ack: got cyc=%0d mask=%b expected cyc=%0d mask=%b",
                             cyc, uart_rx_ack, e.cyc, m);
                end
            end
        end
        if (IO_read_strobe) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL read_data: unexpected read cycle %0d", cyc);
            end else begin
                e = rd_q.pop_front();
                if (e.cyc != cyc || IO_read_data !== e.data) begin
                    errors++;
                    $display("FAIL read_data port %h: got cyc=%0d data=%h expected cyc=%0d data=%h",
                             IO_port_ID, cyc, IO_read_data, e.cyc, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] port, input logic [7:0] d, input int exp_ch);
        exp_t e;
        IO_port_ID      = port;
        IO_write_data   = d;
        IO_write_strobe = 1'b1;
        if (exp_ch >= 0) begin
            e.cyc = cyc + 1; e.ch = exp_ch; e.data = d;
            tx_q.push_back(e);
        end
        tick();
        IO_write_strobe = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [7:0] port, input logic [7:0] exp, input int ack_ch);
        exp_t e;
        IO_port_ID     = port;
        IO_read_strobe = 1'b1;
        e.cyc = cyc; e.ch = 0; e.data = exp;
        rd_q.push_back(e);
        if (ack_ch >= 0) begin
            e.cyc = cyc + 1; e.ch = ack_ch; e.data = 8'h00;
            ack_q.push_back(e);
        end
        tick();
        IO_read_strobe = 1'b0;
        tick();
    endtask

    initial begin : stim
        exp_t e;
        reset           = 1'b1;
        IO_port_ID      = 8'h00;
        IO_write_data   = 8'h00;
        IO_write_strobe = 1'b0;
        IO_read_strobe  = 1'b0;
        uart_tx_full    = '0;
        uart_rx_data    = '0;
        uart_rx_present = '0;
        gpio_in         = '0;
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_tx_write", 32'(uart_tx_write), 32'h0);
        chk("rst_rx_ack",   32'(uart_rx_ack),   32'h0);
        chk("rst_tx_data",  32'(uart_tx_data),  32'h0);
        chk("rst_gpio_out", 32'(gpio_out),      32'h0);
        chk("rst_irq",      32'(irq),           32'h0);
        chk("rst_rd_data",  32'(IO_read_data),  32'h0);
        tick();

        // Held strobe with a port change mid-hold is still a single access.
        IO_port_ID      = 8'h01;
        IO_write_data   = 8'h41;
        IO_write_strobe = 1'b1;
        e.cyc = cyc + 1; e.ch = 0; e.data = 8'h41;
        tx_q.push_back(e);
        tick();
        IO_port_ID = 8'h05;
        tick();
        tick();
        IO_write_strobe = 1'b0;
        tick();
        chk("tx_data_hold", 32'(uart_tx_data), 32'h0041);

        // Channel 1 full: 300 dropped writes saturate the counter.
        uart_tx_full = 2'b10;
        for (int i = 0; i < 300; i++) wr(8'h05, 8'(i), -1);
        uart_tx_full = 2'b00;
        rd(8'h06, 8'h04, -1);
        rd(8'h07, 8'hFF, -1);
        wr(8'h06, 8'h04, -1);
        rd(8'h06, 8'h00, -1);
        rd(8'h07, 8'hFF, -1);
        wr(8'h07, 8'h00, -1);
        rd(8'h07, 8'h00, -1);
        wr(8'h05, 8'hC3, 1);
        chk("tx_data_ch1", 32'(uart_tx_data), 32'hC341);

        // RX read with and without data present.
        uart_rx_data    = 16'h005A;
        uart_rx_present = 2'b01;
        rd(8'h01, 8'h5A, 0);
        uart_rx_present = 2'b00;
        rd(8'h01, 8'h5A, -1);
        rd(8'h02, 8'h08, -1);
        wr(8'h02, 8'h08, -1);
        rd(8'h02, 8'h00, -1);
        IO_port_ID = 8'h01;
        @(negedge clk);
        chk("rd_idle_zero", 32'(IO_read_data), 32'h0);
        tick();

        // Interrupt enable and latency.
        wr(8'h04, 8'h01, -1);
        rd(8'h04, 8'h01, -1);
        uart_rx_present = 2'b01;
        @(negedge clk);
        chk("irq_latency", 32'(irq), 32'h0);
        tick();
        @(negedge clk);
        chk("irq_set", 32'(irq), 32'h1);
        tick();
        wr(8'h04, 8'h00, -1);
        @(negedge clk);
        chk("irq_clear", 32'(irq), 32'h0);
        tick();
        uart_rx_present = 2'b00;

        // GPIO path and fixed ports.
        gpio_in = 8'hA5;
        tick();
        rd(8'hF0, 8'h00, -1);
        rd(8'hF0, 8'hA5, -1);
        wr(8'hF0, 8'h3C, -1);
        @(negedge clk);
        chk("gpio_out", 32'(gpio_out), 32'h3C);
        tick();
        rd(8'hF1, 8'h02, -1);
        rd(8'h09, 8'h00, -1);
        rd(8'hF2, 8'h00, -1);

        // Reset right after a DATA write event cancels the pulse.
        IO_port_ID      = 8'h01;
        IO_write_data   = 8'h77;
        IO_write_strobe = 1'b1;
        tick();
        reset           = 1'b1;
        IO_write_strobe = 1'b0;
        @(negedge clk);
        chk("rst_cancel_pulse", 32'(uart_tx_write), 32'h0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst2_tx_write", 32'(uart_tx_write), 32'h0);
        chk("rst2_tx_data",  32'(uart_tx_data),  32'h0);
        chk("rst2_rx_ack",   32'(uart_rx_ack),   32'h0);
        chk("rst2_gpio_out", 32'(gpio_out),      32'h0);
        chk("rst2_irq",      32'(irq),           32'h0);
        tick();
        tick();

        chk("tx_q_drained",  32'(tx_q.size()),  32'h0);
        chk("ack_q_drained", 32'(ack_q.size()), 32'h0);
        chk("rd_q_drained",  32'(rd_q.size()),  32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

endmodule
`default_nettype wire
